// File: rtl/elem_deque.sv
// elem_deque: circular-buffer double-ended queue of WIDTH-bit elements.
// Optional macro: ELEM_DEQUE_SUM_EN enables the registered running sum on 'sum'.
// Ports:
//   clk, rst_h                      clock, synchronous active-high reset
//   push_back / push_front / din    insert din at the back / front
//   pop_back / pop_front            remove the back / front element
//   dout_front / dout_back          registered front/back element (0 when empty)
//   count / empty / full            registered occupancy and flags
//   err                             one-cycle pulse after a rejected or illegal command
//   sum                             running sum of stored elements (0 unless enabled)
module elem_deque #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_h,
  input  logic                               push_back,
  input  logic                               push_front,
  input  logic                               pop_back,
  input  logic                               pop_front,
  input  logic [WIDTH-1:0]                   din,
  output logic [WIDTH-1:0]                   dout_front,
  output logic [WIDTH-1:0]                   dout_back,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               empty,
  output logic                               full,
  output logic                               err,
  output logic [WIDTH+$clog2(DEPTH)-1:0]     sum
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = WIDTH + PW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_front_q, dout_front_d, dout_back_q, dout_back_d;
  logic             empty_q, empty_d, full_q, full_d, err_q, err_d;

  logic             do_pb, do_pf, do_popb, do_popf;
  logic             is_empty, is_full;
  logic [PW-1:0]    head_m1, tail_m1, tail_d_m1;
  logic [3:0]       cmd;

  // Command decode: decide which operations are accepted this cycle
  always_comb begin
    do_pb    = 1'b0;
    do_pf    = 1'b0;
    do_popb  = 1'b0;
    do_popf  = 1'b0;
    err_d    = 1'b0;
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
    cmd      = {push_back, push_front, pop_back, pop_front};
    case (cmd)
      4'b0000: ;
      4'b1000: if (is_full)  err_d = 1'b1; else do_pb   = 1'b1;
      4'b0100: if (is_full)  err_d = 1'b1; else do_pf   = 1'b1;
      4'b0010: if (is_empty) err_d = 1'b1; else do_popb = 1'b1;
      4'b0001: if (is_empty) err_d = 1'b1; else do_popf = 1'b1;
      // Streaming pairs: when empty only the push lands and the pop is flagged
      4'b1001: begin
        do_pb = 1'b1;
        if (is_empty) err_d = 1'b1; else do_popf = 1'b1;
      end
      4'b0110: begin
        do_pf = 1'b1;
        if (is_empty) err_d = 1'b1; else do_popb = 1'b1;
      end
      default: err_d = 1'b1;
    endcase
  end

  // Next-state: pointers, storage and registered read-out of the new contents
  always_comb begin
    head_m1 = head_q - PW'(1);
    tail_m1 = tail_q - PW'(1);
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pb) begin
      mem_d[tail_q] = din;
      tail_d        = tail_q + PW'(1);
    end
    if (do_pf) begin
      mem_d[head_m1] = din;
      head_d         = head_m1;
    end
    if (do_popf) head_d = head_q + PW'(1);
    if (do_popb) tail_d = tail_m1;
    count_d   = count_q + CW'(do_pb) + CW'(do_pf) - CW'(do_popb) - CW'(do_popf);
    tail_d_m1 = tail_d - PW'(1);
    empty_d   = (count_d == '0);
    full_d    = (count_d == CW'(DEPTH));
    dout_front_d = empty_d ? '0 : mem_d[head_d];
    dout_back_d  = empty_d ? '0 : mem_d[tail_d_m1];
  end

  // Storage needs no reset; contents are don't-care after reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      dout_front_q <= '0;
      dout_back_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      err_q        <= err_d;
      dout_front_q <= dout_front_d;
      dout_back_q  <= dout_back_d;
    end
  end

  assign dout_front = dout_front_q;
  assign dout_back  = dout_back_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign err        = err_q;

`ifdef ELEM_DEQUE_SUM_EN
  logic [SW-1:0] sum_q, sum_d;

  // Running total: add pushed data, subtract the element each accepted pop removes
  always_comb begin
    sum_d = sum_q;
    if (do_pb || do_pf) sum_d = sum_d + SW'(din);
    if (do_popf)        sum_d = sum_d - SW'(mem_q[head_q]);
    if (do_popb)        sum_d = sum_d - SW'(mem_q[tail_m1]);
  end

  always_ff @(posedge clk) begin
    if (rst_h) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

endmodule

// File: tb/tb_elem_deque.sv
// Directed bench for elem_deque (WIDTH=8, DEPTH=8): a table of per-cycle commands
// with hand-computed post-edge expectations, then a wrap-around streaming sequence
// checked against a queue model.
module tb_elem_deque;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
`ifdef ELEM_DEQUE_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_h, push_back, push_front, pop_back, pop_front;
  logic [7:0]  din;
  logic [7:0]  dout_front, dout_back;
  logic [3:0]  count;
  logic        empty, full, err;
  logic [10:0] sum;

  int checks = 0;
  int errors = 0;

  elem_deque #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_h(rst_h),
    .push_back(push_back), .push_front(push_front),
    .pop_back(pop_back), .pop_front(pop_front),
    .din(din), .dout_front(dout_front), .dout_back(dout_back),
    .count(count), .empty(empty), .full(full), .err(err), .sum(sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, pb, pf, popb, popf;
    int       din;
    int       f, b, c;
    bit       e, fl, er;
    int       s;
  } vec_t;

  vec_t vec [64];
  int   nv = 0;

  task automatic add(input bit rst, input bit pb, input bit pf, input bit popb,
                     input bit popf, input int d, input int f, input int b,
                     input int c, input bit er, input int s);
    vec[nv].rst = rst; vec[nv].pb = pb; vec[nv].pf = pf;
    vec[nv].popb = popb; vec[nv].popf = popf; vec[nv].din = d;
    vec[nv].f = f; vec[nv].b = b; vec[nv].c = c;
    vec[nv].e = (c == 0); vec[nv].fl = (c == 8); vec[nv].er = er; vec[nv].s = s;
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input bit rst, input bit pb, input bit pf, input bit popb,
                       input bit popf, input int d);
    @(negedge clk);
    rst_h = rst; push_back = pb; push_front = pf;
    pop_back = popb; pop_front = popf; din = 8'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    rst_h = 1'b0; push_back = 1'b0; push_front = 1'b0;
    pop_back = 1'b0; pop_front = 1'b0; din = '0;
  endtask

  int q [$];

  initial begin
    rst_h = 1'b1; push_back = 1'b0; push_front = 1'b0;
    pop_back = 1'b0; pop_front = 1'b0; din = '0;

    //   rst pb pf pob pof din   front back cnt err sum
    add(1, 0, 0, 0, 0, 0,      0,    0,    0,  0,  0);   // reset state
    add(0, 1, 0, 0, 0, 0,      0,    0,    1,  0,  0);
    add(0, 1, 0, 0, 0, 2,      0,    2,    2,  0,  2);
    add(0, 1, 0, 0, 0, 5,      0,    5,    3,  0,  7);
    add(0, 0, 1, 0, 0, 6,      6,    5,    4,  0,  13);
    add(0, 0, 0, 1, 0, 0,      6,    2,    3,  0,  8);
    add(0, 1, 0, 0, 0, 8,      6,    8,    4,  0,  16);
    add(0, 0, 0, 0, 1, 0,      0,    8,    3,  0,  10);  // {0,2,8}
    add(0, 1, 0, 0, 1, 3,      2,    3,    3,  0,  13);  // stream back-in/front-out
    add(0, 0, 1, 1, 0, 7,      7,    8,    3,  0,  17);  // stream front-in/back-out
    add(0, 0, 0, 1, 1, 0,      7,    8,    3,  1,  17);  // illegal pair
    add(0, 0, 0, 0, 0, 0,      7,    8,    3,  0,  17);  // err is a single pulse
    add(1, 0, 0, 0, 0, 0,      0,    0,    0,  0,  0);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, 0, 0, k,    1,    k,    k,  0,  k*(k+1)/2);
    add(0, 1, 0, 0, 0, 9,      1,    8,    8,  1,  36);  // push while full
    add(0, 0, 0, 0, 0, 0,      1,    8,    8,  0,  36);
    add(0, 1, 0, 0, 1, 9,      2,    9,    8,  0,  44);  // stream while full
    add(0, 0, 1, 1, 0, 'h55,   'h55, 8,    8,  0,  120); // stream while full, other pair
    add(1, 0, 0, 0, 0, 0,      0,    0,    0,  0,  0);
    add(0, 0, 1, 0, 0, 'hAA,   'hAA, 'hAA, 1,  0,  170); // head wraps to DEPTH-1
    add(0, 0, 1, 0, 0, 'hBB,   'hBB, 'hAA, 2,  0,  357);
    add(0, 0, 0, 1, 0, 0,      'hBB, 'hBB, 1,  0,  187); // tail wraps from 0
    add(0, 0, 0, 1, 0, 0,      0,    0,    0,  0,  0);
    add(0, 0, 0, 0, 1, 0,      0,    0,    0,  1,  0);   // pop while empty
    add(0, 1, 1, 0, 0, 4,      0,    0,    0,  1,  0);   // illegal double push
    add(0, 1, 0, 0, 1, 'h11,   'h11, 'h11, 1,  1,  17);  // stream while empty
    add(0, 0, 1, 1, 0, 'h22,   'h22, 'h22, 1,  0,  34);  // stream at count 1
    add(0, 0, 0, 0, 1, 0,      0,    0,    0,  0,  0);
    add(0, 0, 0, 1, 0, 0,      0,    0,    0,  1,  0);
    for (int k = 1; k <= 5; k++)
      add(0, 1, 0, 0, 0, k,    1,    k,    k,  0,  k*(k+1)/2);
    add(1, 1, 0, 0, 0, 9,      0,    0,    0,  0,  0);   // reset wins over push
    add(0, 1, 0, 0, 0, 7,      7,    7,    1,  0,  7);

    for (int i = 0; i < nv; i++) begin
      apply(vec[i].rst, vec[i].pb, vec[i].pf, vec[i].popb, vec[i].popf, vec[i].din);
      chk("dout_front", i, int'(dout_front), vec[i].f);
      chk("dout_back",  i, int'(dout_back),  vec[i].b);
      chk("count",      i, int'(count),      vec[i].c);
      chk("empty",      i, int'(empty),      int'(vec[i].e));
      chk("full",       i, int'(full),       int'(vec[i].fl));
      chk("err",        i, int'(err),        int'(vec[i].er));
      chk("sum",        i, int'(sum),        SUM_EN ? vec[i].s : 0);
    end

    // Streaming across several pointer wraps, checked against a queue model
    apply(1, 0, 0, 0, 0, 0);
    q.delete();
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 0, 0, 0, 10 + k);
      q.push_back(10 + k);
    end
    for (int k = 0; k < 12; k++) begin
      apply(0, 1, 0, 0, 1, 20 + k);
      q.push_back(20 + k);
      void'(q.pop_front());
      chk("wrap_front", 100 + k, int'(dout_front), q[0]);
      chk("wrap_back",  100 + k, int'(dout_back),  q[$]);
      chk("wrap_count", 100 + k, int'(count),      q.size());
      chk("wrap_err",   100 + k, int'(err),        0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elem_deque.md
Name: elem_deque

Overview:
Hardware double-ended queue buffering WIDTH-bit elements between the stimulus producer and the downstream ordering/checker stage. It implements the push_front/push_back/pop_front/pop_back semantics the testbench models with SystemVerilog queues, so the bench can compare RTL order against its own queue model. It is a circular register buffer with head/tail pointers, occupancy count, full/empty flags and an error pulse.

Parameters:
WIDTH, 8, element width in bits
DEPTH, 8, number of entries; must be a power of 2, minimum 2

Ports:
clk  input  1  single clock, rising edge
rst_h  input  1  synchronous active-high reset
push_back  input  1  append din at the back
push_front  input  1  insert din at the front
pop_back  input  1  remove the back element
pop_front  input  1  remove the front element
din  input  WIDTH  data for push
dout_front  output  WIDTH  current front element; 0 when empty
dout_back  output  WIDTH  current back element; 0 when empty
count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
err  output  1  one-cycle pulse on an illegal or rejected command
sum  output  WIDTH+$clog2(DEPTH)  running sum of stored elements (see Optional Feature)

Behaviour:
- Reset: clk and rst_h as named above. Reset is synchronous and active-high: with rst_h=1 at a clk edge, head=0, tail=0, count=0, empty=1, full=0, err=0, dout_front=0, dout_back=0, sum=0. Storage contents are don't-care.
- Reset mid-operation: all commands in the reset cycle are ignored and existing contents are discarded.
- Pointers: head indexes the front element; tail indexes the next free slot after the back element. Both wrap modulo DEPTH.
- Command effects, all committed at the clk edge:
  - push_back: mem[tail]=din; tail+1; count+1.
  - push_front: head-1; mem[head-1]=din; count+1.
  - pop_front: head+1; count-1.
  - pop_back: tail-1; count-1.
- Outputs: dout_front, dout_back, count, empty and full are all registered state and reflect the post-edge contents. Read latency is 0 cycles after the commit edge. When count==1, dout_front equals dout_back.
- Legal combinations per cycle: no command; any single command; push_back+pop_front; push_front+pop_back.
  - In a streaming pair, count is unchanged.
  - Streaming pair while full: both operations succeed and count stays DEPTH.
  - Streaming pair while empty: the push succeeds, the pop is ignored, err=1, and count becomes 1.
- Illegal combinations: any other multi-command set, e.g. push_back+push_front or pop_front+pop_back. No state change; err=1 for one cycle.
- Push while full, without a same-cycle pop: ignored; err=1.
- Pop while empty: ignored; err=1.
- err is registered. It is 1 in the cycle after the offending edge and 0 otherwise.
- Wrap-around: push_front at head=0 moves head to DEPTH-1. pop_back at tail=0 moves tail to DEPTH-1.

Optional Feature:
- Macro: ELEM_DEQUE_SUM_EN.
- Defined: sum is a registered running total of all stored elements. It adds din on each accepted push and subtracts the removed element on each accepted pop; in a streaming pair both are applied in the same cycle. Reset value is 0. sum never overflows, because its width covers DEPTH*(2^WIDTH-1).
- Not defined: the port exists but is tied to 0, and no adder logic is built.

Test Plan:
- Reset, then push_back 0, 2, 5 -> count=3, dout_front=0, dout_back=5, empty=0; with ELEM_DEQUE_SUM_EN, sum=7.
- From {0,2,5}: push_front 6, then pop_back -> deque {6,0,2}, dout_front=6, dout_back=2; push_back 8, then pop_front -> {0,2,8}, count=3, err never asserted.
- Fill DEPTH=8 with 1..8, then push_back 9 -> err=1 for one cycle, count=8, full=1, dout_back=8. Then push_back 9 with pop_front -> dout_front=2, dout_back=9, count=8.
- Wrap-around: from reset, push_front 0xAA, push_front 0xBB -> head=6, dout_front=0xBB, dout_back=0xAA. Then pop_back twice -> empty=1, dout_front=0, dout_back=0, err=0.
- Empty deque: pop_front -> err=1, count=0. Then push_back+push_front together -> err=1, no state change. Then push_back 0x11 with pop_front -> count=1, err=1, dout_front=0x11.
- Mid-operation reset: with 5 elements held, assert rst_h for one cycle together with push_back -> count=0, empty=1, err=0, sum=0.
